// File: rtl/voq_egress_reader.sv
// ---------------------------------------------------------------------------
// voq_egress_reader
//
// Egress end of the crossbar->VOQ path, one instance per output port.
// Frame start pointers pushed by the crossbar are queued in a small FIFO.
// Each frame is then read from the shared packet buffer one word at a time
// and streamed to the TX MAC under valid/ready. When the last word of a
// frame is accepted, a one-cycle done pulse returns the start pointer so
// the buffer space can be released.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   voq_write_req_i   push voq_start_ptr_i into the pointer FIFO
//   voq_start_ptr_i   first buffer address of the frame
//   voq_full_o        FIFO holds VOQ_DEPTH entries (registered)
//   voq_empty_o       FIFO holds no entries (registered)
//   mem_rd_en_o       packet buffer read strobe
//   mem_rd_addr_o     packet buffer read address
//   mem_rd_data_i     read data, valid one cycle after mem_rd_en_o
//   mem_rd_eop_i      last-word flag stored with the data, same timing
//   tx_data_o         TX stream data
//   tx_valid_o        TX word valid
//   tx_last_o         last word of the frame
//   tx_ready_i        TX MAC accepts the word
//   pkt_done_o        one-cycle pulse when a frame has been fully sent
//   pkt_done_ptr_o    start pointer of the completed frame
//   trunc_o           with pkt_done_o: frame was cut at MAX_WORDS
//   drop_cnt_o        (only with VOQ_DROP_CNT_EN) saturating count of
//                     pushes dropped because the FIFO was full
//
// Build option
//   VOQ_DROP_CNT_EN   adds drop_cnt_o and its counter; without it, drops
//                     are silent.
//
// FSM states
//   state | meaning
//   IDLE  | waiting for a queued pointer; pops the head on exit
//   READ  | buffer read strobe for the current address
//   WAIT  | read data arrives; captured into the TX registers
//   SEND  | TX word presented, held until tx_ready_i
// ---------------------------------------------------------------------------
module voq_egress_reader #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 8,
    parameter int VOQ_DEPTH = 8,
    parameter int MAX_WORDS = 2048
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              voq_write_req_i,
    input  logic [ADDR_W-1:0] voq_start_ptr_i,
    output logic              voq_full_o,
    output logic              voq_empty_o,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_rd_addr_o,
    input  logic [DATA_W-1:0] mem_rd_data_i,
    input  logic              mem_rd_eop_i,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              tx_valid_o,
    output logic              tx_last_o,
    input  logic              tx_ready_i,
    output logic              pkt_done_o,
    output logic [ADDR_W-1:0] pkt_done_ptr_o,
    output logic              trunc_o
`ifdef VOQ_DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt_o
`endif
);

    localparam int PTR_W = $clog2(VOQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WC_W  = $clog2(MAX_WORDS + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(VOQ_DEPTH);
    localparam logic [WC_W-1:0]  MAX_CNT   = WC_W'(MAX_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2,
        SEND = 2'd3
    } state_t;

    state_t state, state_next;

    // ---------------- pointer FIFO ----------------
    logic [ADDR_W-1:0] fifo_mem [VOQ_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt, cnt_next;
    logic              full_q, empty_q;
    logic              pop, push_ok;
    logic [ADDR_W-1:0] head;

    assign head    = fifo_mem[rd_ptr];
    assign pop     = (state == IDLE) && !empty_q;
    // A push into a full FIFO still fits when the head leaves the same cycle.
    assign push_ok = voq_write_req_i && (!full_q || pop);

    always_comb begin
        cnt_next = fifo_cnt;
        if (push_ok && !pop) begin
            cnt_next = fifo_cnt + CNT_W'(1);
        end else if (!push_ok && pop) begin
            cnt_next = fifo_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_cnt <= cnt_next;
            full_q   <= (cnt_next == DEPTH_CNT);
            empty_q  <= (cnt_next == '0);
        end
    end

    // Storage needs no reset: occupancy is tracked by fifo_cnt alone.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= voq_start_ptr_i;
        end
    end

    assign voq_full_o  = full_q;
    assign voq_empty_o = empty_q;

`ifdef VOQ_DROP_CNT_EN
    logic        drop;
    logic [15:0] drop_cnt;

    assign drop = voq_write_req_i && full_q && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign drop_cnt_o = drop_cnt;
`else
    // Dropped pushes leave no trace in this build.
`endif

    // ---------------- frame datapath ----------------
    logic [ADDR_W-1:0] cur_ptr, addr;
    logic [DATA_W-1:0] data_q;
    logic              eop_q;
    logic [WC_W-1:0]   word_cnt;
    logic              last_word;

    // The length guard closes a frame even when no eop was stored.
    assign last_word = eop_q || (word_cnt == MAX_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_ptr  <= '0;
            addr     <= '0;
            data_q   <= '0;
            eop_q    <= 1'b0;
            word_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty_q) begin
                        cur_ptr  <= head;
                        addr     <= head;
                        word_cnt <= '0;
                    end
                end
                WAIT: begin
                    data_q <= mem_rd_data_i;
                    eop_q  <= mem_rd_eop_i;
                    if (word_cnt != MAX_CNT) begin
                        word_cnt <= word_cnt + WC_W'(1);
                    end
                end
                SEND: begin
                    // Address wraps naturally at 2**ADDR_W.
                    if (tx_ready_i && !last_word) begin
                        addr <= addr + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (!empty_q) state_next = READ;
            READ: state_next = WAIT;
            WAIT: state_next = SEND;
            SEND: begin
                if (tx_ready_i) begin
                    state_next = last_word ? IDLE : READ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_rd_en_o    = 1'b0;
        mem_rd_addr_o  = '0;
        tx_valid_o     = 1'b0;
        tx_last_o      = 1'b0;
        pkt_done_o     = 1'b0;
        pkt_done_ptr_o = '0;
        trunc_o        = 1'b0;
        case (state)
            READ: begin
                mem_rd_en_o   = 1'b1;
                mem_rd_addr_o = addr;
            end
            SEND: begin
                tx_valid_o = 1'b1;
                tx_last_o  = last_word;
                if (tx_ready_i && last_word) begin
                    pkt_done_o     = 1'b1;
                    pkt_done_ptr_o = cur_ptr;
                    trunc_o        = !eop_q;
                end
            end
            default: ;
        endcase
    end

    assign tx_data_o = data_q;

endmodule

// File: tb/tb_voq_egress_reader.sv
module tb_voq_egress_reader;

    localparam int AW    = 12;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int MAXW  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          voq_write_req_i = 1'b0;
    logic [AW-1:0] voq_start_ptr_i = '0;
    logic          voq_full_o, voq_empty_o;
    logic          mem_rd_en_o;
    logic [AW-1:0] mem_rd_addr_o;
    logic [DW-1:0] mem_rd_data_i = '0;
    logic          mem_rd_eop_i = 1'b0;
    logic [DW-1:0] tx_data_o;
    logic          tx_valid_o, tx_last_o;
    logic          tx_ready_i = 1'b0;
    logic          pkt_done_o;
    logic [AW-1:0] pkt_done_ptr_o;
    logic          trunc_o;
`ifdef VOQ_DROP_CNT_EN
    logic [15:0]   drop_cnt_o;
`endif

    voq_egress_reader #(
        .ADDR_W(AW), .DATA_W(DW), .VOQ_DEPTH(DEPTH), .MAX_WORDS(MAXW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .voq_write_req_i(voq_write_req_i), .voq_start_ptr_i(voq_start_ptr_i),
        .voq_full_o(voq_full_o), .voq_empty_o(voq_empty_o),
        .mem_rd_en_o(mem_rd_en_o), .mem_rd_addr_o(mem_rd_addr_o),
        .mem_rd_data_i(mem_rd_data_i), .mem_rd_eop_i(mem_rd_eop_i),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_last_o(tx_last_o),
        .tx_ready_i(tx_ready_i),
        .pkt_done_o(pkt_done_o), .pkt_done_ptr_o(pkt_done_ptr_o), .trunc_o(trunc_o)
`ifdef VOQ_DROP_CNT_EN
        , .drop_cnt_o(drop_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Packet buffer: {eop, data} per address, one-cycle read latency.
    logic [8:0] mem [4096];
    always @(posedge clk) begin
        if (mem_rd_en_o) begin
            mem_rd_data_i <= mem[mem_rd_addr_o][7:0];
            mem_rd_eop_i  <= mem[mem_rd_addr_o][8];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [8:0]  exp_beats [$];   // {last, data}
    logic [12:0] exp_done  [$];   // {trunc, ptr}

    // A frame ends on its eop word or after MAXW words, whichever comes first.
    function automatic void expect_frame(input logic [11:0] ptr);
        logic [8:0] e;
        logic       last;
        for (int i = 0; i < MAXW; i++) begin
            e    = mem[ptr + 12'(i)];
            last = e[8] || (i == MAXW - 1);
            exp_beats.push_back({last, e[7:0]});
            if (last) begin
                exp_done.push_back({!e[8], ptr});
                break;
            end
        end
    endfunction

    function automatic void write_frame(input logic [11:0] ptr, input int n,
                                        input int eop_at, input logic [7:0] seed);
        for (int i = 0; i < n; i++) begin
            mem[ptr + 12'(i)] = {(i + 1 == eop_at), seed + 8'(i * 17)};
        end
    endfunction

    // ---------------- monitor / scoreboard ----------------
    int         cyc = 0;
    int         beat_cnt = 0;
    int         done_cnt = 0;
    logic       last_trunc = 1'b0;
    int         beat_cyc [$];
    logic [11:0] rd_log [$];

    always @(negedge clk) begin
        logic [8:0]  eb;
        logic [12:0] ed;
        cyc++;
        if (rst_n) begin
            if (mem_rd_en_o) rd_log.push_back(mem_rd_addr_o);
            if (tx_valid_o && tx_ready_i) begin
                beat_cyc.push_back(cyc);
                beat_cnt++;
                if (exp_beats.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL beat_expected: got data %0h, none expected", tx_data_o);
                end else begin
                    eb = exp_beats.pop_front();
                    check("beat_data", tx_data_o, eb[7:0]);
                    check("beat_last", tx_last_o, eb[8]);
                end
            end
            if (pkt_done_o) begin
                done_cnt++;
                last_trunc = trunc_o;
                if (exp_done.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL done_expected: got ptr %0h, none expected", pkt_done_ptr_o);
                end else begin
                    ed = exp_done.pop_front();
                    check("done_ptr", pkt_done_ptr_o, ed[11:0]);
                    check("done_trunc", trunc_o, ed[12]);
                end
            end
            check("done_align", pkt_done_o, tx_valid_o & tx_ready_i & tx_last_o);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [11:0] ptr, input bit accept);
        voq_write_req_i = 1'b1;
        voq_start_ptr_i = ptr;
        if (accept) expect_frame(ptr);
        step();
        voq_write_req_i = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget && done_cnt < target; i++) step();
        check("wait_done", done_cnt >= target, 1);
    endtask

    task automatic wait_valid(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx_valid_o) break;
        end
        check("wait_valid", i < budget, 1);
    endtask

    typedef struct {
        logic [11:0] ptr;
        int          n;
        int          eop_at;
        int          exp_beats;
        logic        exp_trunc;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int base_b, base_d, lat, pushed;
        logic [11:0] exp_addr [4];

        vecs[0] = '{12'h500, 1, 1, 1, 1'b0};
        vecs[1] = '{12'h510, 6, 0, 4, 1'b1};   // no eop: cut at 4 words
        vecs[2] = '{12'h520, 4, 4, 4, 1'b0};   // eop exactly at the guard
        vecs[3] = '{12'h530, 5, 5, 4, 1'b1};   // eop beyond the guard
        vecs[4] = '{12'h540, 2, 2, 2, 1'b0};
        vecs[5] = '{12'h550, 3, 2, 2, 1'b0};   // word after eop never sent

        for (int i = 0; i < 4096; i++) mem[i] = '0;

        // Reset state
        repeat (3) step();
        @(negedge clk);
        check("rst_empty", voq_empty_o, 1);
        check("rst_full", voq_full_o, 0);
        check("rst_valid", tx_valid_o, 0);
        check("rst_rd_en", mem_rd_en_o, 0);
        check("rst_done", pkt_done_o, 0);
        step();
        rst_n = 1'b1;

        // Idle after reset release
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_quiet", {voq_empty_o, tx_valid_o, mem_rd_en_o}, 3'b100);
        end
        step();

        // Three-word frame, ready high
        tx_ready_i = 1'b1;
        mem[12'h010] = {1'b0, 8'hAA};
        mem[12'h011] = {1'b0, 8'hBB};
        mem[12'h012] = {1'b1, 8'hCC};
        rd_log.delete();
        beat_cyc.delete();
        base_d = done_cnt;
        push_one(12'h010, 1);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (tx_valid_o) break;
        end
        // push lands, FIFO seen non-empty, READ, WAIT, then SEND
        check("first_valid_latency", lat, 4);
        wait_done(base_d + 1, 50);
        check("f2_beats", beat_cyc.size(), 3);
        if (beat_cyc.size() == 3) check("f2_spacing", beat_cyc[2] - beat_cyc[0], 6);
        check("f2_reads", rd_log.size(), 3);
        if (rd_log.size() == 3) check("f2_addr_last", rd_log[2], 12'h012);

        // Address wrap
        write_frame(12'hFFE, 4, 4, 8'h60);
        exp_addr = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        rd_log.delete();
        base_d = done_cnt;
        push_one(12'hFFE, 1);
        wait_done(base_d + 1, 60);
        check("wrap_reads", rd_log.size(), 4);
        for (int i = 0; i < 4 && i < rd_log.size(); i++) check("wrap_addr", rd_log[i], exp_addr[i]);

        // Back-pressure mid-frame
        tx_ready_i = 1'b0;
        mem[12'h100] = {1'b0, 8'h11};
        mem[12'h101] = {1'b0, 8'h42};
        mem[12'h102] = {1'b1, 8'h33};
        base_b = beat_cnt;
        base_d = done_cnt;
        push_one(12'h100, 1);
        wait_valid(20);
        step();
        tx_ready_i = 1'b1;
        step();
        tx_ready_i = 1'b0;
        wait_valid(20);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", tx_valid_o, 1);
            check("stall_data", tx_data_o, 8'h42);
            check("stall_last", tx_last_o, 0);
            check("stall_no_read", mem_rd_en_o, 0);
            @(negedge clk);
        end
        step();
        tx_ready_i = 1'b1;
        wait_done(base_d + 1, 50);
        check("stall_beats", beat_cnt - base_b, 3);

        // FIFO overflow while the reader is stalled
        tx_ready_i = 1'b0;
        write_frame(12'h200, 4, 4, 8'h80);
        base_d = done_cnt;
        push_one(12'h200, 1);
        wait_valid(20);
        step();
        for (int k = 0; k < 9; k++) write_frame(12'h300 + 12'(k * 16), (k % 2) + 1, (k % 2) + 1, 8'(k * 8));
        for (int k = 0; k < 9; k++) begin
            voq_write_req_i = 1'b1;
            voq_start_ptr_i = 12'h300 + 12'(k * 16);
            if (k < 8) expect_frame(voq_start_ptr_i);
            step();
        end
        voq_write_req_i = 1'b0;
        @(negedge clk);
        check("ovf_full", voq_full_o, 1);
        check("ovf_empty", voq_empty_o, 0);
`ifdef VOQ_DROP_CNT_EN
        check("ovf_drop_cnt", drop_cnt_o, 16'd1);
`endif
        // Push on the exact cycle the full FIFO pops: must be accepted
        write_frame(12'h3A0, 1, 1, 8'hE5);
        step();
        tx_ready_i = 1'b1;
        begin
            int i;
            for (i = 0; i < 40; i++) begin
                @(negedge clk);
                if (pkt_done_o) break;
            end
            check("busy_done_seen", i < 40, 1);
        end
        step();
        push_one(12'h3A0, 1);
        @(negedge clk);
        check("full_pop_push_full", voq_full_o, 1);
`ifdef VOQ_DROP_CNT_EN
        check("full_pop_push_drop_cnt", drop_cnt_o, 16'd1);
`endif
        step();
        wait_done(base_d + 10, 400);
        @(negedge clk);
        check("ovf_drained", voq_empty_o, 1);
        step();

        // Table of frame shapes
        tx_ready_i = 1'b1;
        foreach (vecs[v]) begin
            write_frame(vecs[v].ptr, vecs[v].n, vecs[v].eop_at, 8'(v * 31 + 5));
            base_b = beat_cnt;
            base_d = done_cnt;
            push_one(vecs[v].ptr, 1);
            wait_done(base_d + 1, 100);
            check("vec_beats", beat_cnt - base_b, vecs[v].exp_beats);
            check("vec_trunc", last_trunc, vecs[v].exp_trunc);
        end

        // Reset in the middle of a frame
        write_frame(12'h800, 4, 4, 8'h21);
        write_frame(12'h810, 1, 1, 8'h22);
        write_frame(12'h820, 1, 1, 8'h23);
        base_b = beat_cnt;
        push_one(12'h800, 1);
        push_one(12'h810, 1);
        push_one(12'h820, 1);
        for (int i = 0; i < 40 && beat_cnt < base_b + 1; i++) step();
        wait_valid(20);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", tx_valid_o, 0);
        check("arst_data", tx_data_o, 0);
        check("arst_last", tx_last_o, 0);
        check("arst_rd_en", mem_rd_en_o, 0);
        check("arst_done", pkt_done_o, 0);
        check("arst_empty", voq_empty_o, 1);
        exp_beats.delete();
        exp_done.delete();
        base_d = done_cnt;
        repeat (2) step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("post_rst_quiet", {voq_empty_o, tx_valid_o, mem_rd_en_o, pkt_done_o}, 4'b1000);
        end
        check("post_rst_no_done", done_cnt - base_d, 0);
        step();

        // Randomized traffic with random back-pressure
        base_d = done_cnt;
        pushed = 0;
        for (int c = 0; c < 4000; c++) begin
            if (pushed == 40 && done_cnt - base_d == 40) break;
            tx_ready_i = ($urandom_range(0, 3) != 0);
            if (pushed < 40 && (pushed - (done_cnt - base_d)) < DEPTH && $urandom_range(0, 2) == 0) begin
                logic [11:0] p;
                int n;
                p = 12'h900 + 12'(pushed * 8);
                n = $urandom_range(1, 6);
                write_frame(p, n, $urandom_range(0, n), 8'($urandom));
                voq_write_req_i = 1'b1;
                voq_start_ptr_i = p;
                expect_frame(p);
                pushed++;
            end else begin
                voq_write_req_i = 1'b0;
            end
            step();
        end
        voq_write_req_i = 1'b0;
        tx_ready_i = 1'b1;
        check("rand_pushed", pushed, 40);
        check("rand_done", done_cnt - base_d, 40);
        check("rand_beats_left", exp_beats.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
